// File: rtl/mult_pkg.sv
// Shared definitions for the multiply sequencer: state encoding and default
// timing constants used by the sequencer and its parent.
package mult_pkg;

  // RUN cycles before a multiplier ready flag is trusted.
  localparam int MIN_CYC_DEF = 8;
  // RUN cycles after which the product is forced out with an error flag.
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_sequencer.sv
// Drives an external iterative multiplier: latches one operand pair, gives the
// multiplier a load cycle, lets it iterate, and captures the product either on a
// qualified ready flag or on timeout. Results are held until the consumer takes them.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int MIN_CYC = MIN_CYC_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        mul_en,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic        mul_ready,
  input  logic [15:0] mul_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product,
  output logic        out_err,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [CW-1:0]   run_cnt;
  logic            qual_ready;
  logic            timeout_hit;

  // The multiplier keeps ready high from the previous operation, so ready is
  // only believed once enough iterations have elapsed in this operation.
  assign qual_ready  = (run_cnt >= CW'(MIN_CYC)) && mul_ready;
  assign timeout_hit = (run_cnt == CW'(TIMEOUT - 1));

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      run_cnt     <= '0;
      in_ready    <= 1'b1;
      mul_en      <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Operands are only ever written here; the multiplier output depends
          // combinationally on them, so they must stay put for the whole operation.
          if (in_valid && in_ready) begin
            mul_a    <= in_a;
            mul_b    <= in_b;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          run_cnt <= '0;
          mul_en  <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          if (qual_ready || timeout_hit) begin
            // A genuine ready on the timeout edge still counts as success.
            out_product <= mul_product;
            out_err     <= ~qual_ready;
            out_valid   <= 1'b1;
            mul_en      <= 1'b0;
            state       <= DONE;
          end else if (run_cnt != CW'(TIMEOUT)) begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter MIN_CYC, default 8: RUN cycles before mul_ready is honoured.
REQ-003 Parameter TIMEOUT, default 16: RUN cycles after which the product is forced out with an error.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  operand pair offered.
REQ-007 in_ready  out  1  sequencer accepts operands.
REQ-008 in_a, in_b  in  8 each  signed two's-complement operands.
REQ-009 mul_en  out  1  multiplier enable (0 = load, 1 = iterate).
REQ-010 mul_a, mul_b  out  8 each  registered operands driven to the multiplier.
REQ-011 mul_ready  in  1  multiplier done flag.
REQ-012 mul_product  in  16  multiplier result, combinational on mul_a/mul_b.
REQ-013 out_valid  out  1  result held.
REQ-014 out_ready  in  1  consumer accepts result.
REQ-015 out_product  out  16  captured signed product.
REQ-016 out_err  out  1  result was captured on timeout, not on mul_ready.
REQ-017 busy  out  1  state is not IDLE.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, LOAD, RUN, DONE.
REQ-019 IDLE: in_ready=1, mul_en=0; on in_valid&&in_ready, latch in_a/in_b into mul_a/mul_b and go to LOAD.
REQ-020 LOAD: one cycle, mul_en=0, so the multiplier initialises from the stable mul_a/mul_b; then go to RUN with run_cnt=0.
REQ-021 RUN: mul_en=1; run_cnt increments each cycle and saturates at TIMEOUT.
REQ-022 RUN: mul_ready SHALL be ignored while run_cnt<MIN_CYC, because the multiplier does not clear ready on load and a stale ready from the prior operation persists.
REQ-023 RUN: on an edge with run_cnt>=MIN_CYC and mul_ready=1, capture mul_product into out_product, clear out_err, and go to DONE.
REQ-024 RUN: on an edge with run_cnt==TIMEOUT-1 and no qualified ready, capture mul_product, set out_err=1, and go to DONE.
REQ-025 If REQ-023 and REQ-024 hold on the same edge, REQ-023 SHALL win and out_err SHALL be 0.
REQ-026 DONE: out_valid=1, mul_en=0; out_product and out_err hold stable until out_valid&&out_ready, then go to IDLE.
REQ-027 mul_a/mul_b SHALL NOT change outside IDLE acceptance, since mul_product depends combinationally on the operand signs.
REQ-028 in_ready SHALL be 0 in LOAD, RUN and DONE; there is no buffering of a second request.
REQ-029 Latency with the 8-bit multiplier: accept edge to out_valid high = 1 LOAD + 10 RUN cycles = 11 cycles.
REQ-030 Operands SHALL be passed through unmodified; -128 handling is the multiplier's responsibility.
REQ-031 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-032 When rst_n=0, the block SHALL asynchronously go to: state IDLE, mul_en=0, mul_a=mul_b=0, run_cnt=0, out_valid=0, out_product=0, out_err=0, busy=0, in_ready=1 once rst_n is released.
REQ-033 Reset asserted mid-operation SHALL abandon the operation; no out_valid SHALL be produced for it.

Structure
REQ-034 The state encoding and the constants MIN_CYC_DEF=8 and TIMEOUT_DEF=16 SHALL reside in the shared package mult_pkg.
REQ-035 The block SHALL be a single module with no sub-module; the multiplier is instantiated by the parent alongside it.

Verification
REQ-036 in_a=7, in_b=-3 (0xFD), out_ready=1 -> out_product=0xFFEB (-21), out_err=0, out_valid high 11 cycles after acceptance.
REQ-037 Back-to-back: 5×6 then -4×-4 with a stale mul_ready=1 left high from the first operation -> second result 0x0010, not 0x001E.
REQ-038 mul_ready tied to 0 -> out_err=1, out_valid high TIMEOUT+1 cycles after acceptance, out_product equals mul_product at capture.
REQ-039 out_ready held 0 for 5 cycles in DONE -> out_product/out_valid stable; in_valid=1 during this window -> in_ready stays 0.
REQ-040 rst_n pulsed low during RUN -> immediate IDLE, out_valid never asserts, next request 2×2 -> out_product=0x0004.
REQ-041 in_a=127, in_b=127 -> out_product=0x3F01.
